// File: rtl/lcd_text_frame_gen.sv
// Character generator for the HD44780 LCD writer: index in, ASCII out one cycle later.
// Optional edit-field blinking is compiled in with `define LCD_BLINK_EN.
module lcd_text_frame_gen #(
    parameter int COLS      = 16,
    parameter int ROWS      = 2,
    parameter int IDX_W     = 5,
    parameter int TIME_ROW  = 1,
    parameter int TIME_COL  = 0,
    parameter int BLINK_DIV = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [IDX_W-1:0] index,
    input  logic [1:0]       mode,
    input  logic [7:0]       hr_bcd,
    input  logic [7:0]       min_bcd,
    input  logic [7:0]       sec_bcd,
    input  logic [1:0]       edit_sel,
    output logic [7:0]       out,
    output logic             out_valid
);

    localparam int N = COLS * ROWS;

    localparam logic [1:0] MODE_BANNER       = 2'd0;
    localparam logic [1:0] MODE_CLOCK        = 2'd1;
    localparam logic [1:0] MODE_CLOCK_BANNER = 2'd2;

    localparam logic [127:0] BANNER_ROW0 = "20173291        ";
    localparam logic [127:0] BANNER_ROW1 = "Bae Hyeon Han   ";

    logic [1:0] mode_q, mode_d;
    logic [7:0] hr_q, hr_d, min_q, min_d, sec_q, sec_d;
    logic [7:0] out_q, out_d;
    logic       valid_q;
    logic       snap;
    logic       blank_digit;

    int idx_i, row, col, pos;
    logic [7:0] banner_c, time_c;
    logic       in_time;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
    endfunction

`ifdef LCD_BLINK_EN
    localparam int CNT_W = $clog2(BLINK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [1:0]       edit_q, edit_d;
    logic             phase_snap_q, phase_snap_d;
    int               blink_grp;

    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
        edit_d       = snap ? edit_sel : edit_q;
        phase_snap_d = snap ? phase_q : phase_snap_q;
        case (edit_d)
            2'd3:    blink_grp = 0;
            2'd2:    blink_grp = 1;
            2'd1:    blink_grp = 2;
            default: blink_grp = -1;
        endcase
        // Separators (pos 2 and 5) never blink; only the two digits of the selected field do.
        blank_digit = phase_snap_d && (blink_grp >= 0) && (pos >= 0) && (pos != 2) && (pos != 5)
                      && ((pos / 3) == blink_grp);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            edit_q       <= 2'd0;
            phase_snap_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            edit_q       <= edit_d;
            phase_snap_q <= phase_snap_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg  = (^edit_sel) ^ (BLINK_DIV < 2);
    assign blank_digit = 1'b0;
`endif

    // The index-0 request uses the values it is latching, so the whole frame is coherent.
    always_comb begin
        snap   = req && (index == '0);
        mode_d = snap ? mode    : mode_q;
        hr_d   = snap ? hr_bcd  : hr_q;
        min_d  = snap ? min_bcd : min_q;
        sec_d  = snap ? sec_bcd : sec_q;

        idx_i = 32'(index);
        row   = idx_i / COLS;
        col   = idx_i % COLS;
        pos   = col - TIME_COL;

        banner_c = 8'h20;
        if (row < 2 && col < 16)
            banner_c = (row == 0) ? BANNER_ROW0[8*(15-col) +: 8] : BANNER_ROW1[8*(15-col) +: 8];

        in_time = (row == TIME_ROW) && (col >= TIME_COL) && (col < TIME_COL + 8);

        case (pos)
            0:       time_c = digit_char(hr_d[7:4]);
            1:       time_c = digit_char(hr_d[3:0]);
            3:       time_c = digit_char(min_d[7:4]);
            4:       time_c = digit_char(min_d[3:0]);
            6:       time_c = digit_char(sec_d[7:4]);
            7:       time_c = digit_char(sec_d[3:0]);
            default: time_c = 8'h3A;
        endcase
        if (blank_digit)
            time_c = 8'h20;

        case (mode_d)
            MODE_BANNER:       out_d = banner_c;
            MODE_CLOCK:        out_d = in_time ? time_c : 8'h20;
            MODE_CLOCK_BANNER: out_d = in_time ? time_c : banner_c;
            default:           out_d = 8'h20;
        endcase
        if (idx_i >= N)
            out_d = 8'h20;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= 2'd0;
            hr_q    <= 8'h00;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            out_q   <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            valid_q <= req;
            if (req)
                out_q <= out_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_lcd_text_frame_gen.sv
// Bench for lcd_text_frame_gen: 16x2 and 20x2 instances against a frame-level character model.
module tb_lcd_text_frame_gen;

    localparam int BDIV  = 4;
    localparam int T_ROW = 1;
    localparam int T_COL = 0;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] hr;
        logic [7:0] mn;
        logic [7:0] sc;
        logic [1:0] edit;
        logic       phase;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic [4:0] index = '0;
    logic       req20 = 1'b0;
    logic [5:0] index20 = '0;
    logic [1:0] mode = 2'd0;
    logic [7:0] hr_bcd = 8'h00, min_bcd = 8'h00, sec_bcd = 8'h00;
    logic [1:0] edit_sel = 2'd0;
    logic [7:0] out_a, out_b;
    logic       valid_a, valid_b;

    int    errors = 0;
    int    checks = 0;
    int    cyc;
    snap_t s_a, s_b;
    logic [7:0] last_a, last_b;

    lcd_text_frame_gen #(.COLS(16), .ROWS(2), .IDX_W(5), .TIME_ROW(T_ROW), .TIME_COL(T_COL),
                         .BLINK_DIV(BDIV)) u_dut (
        .clk(clk), .rst(rst), .req(req), .index(index), .mode(mode),
        .hr_bcd(hr_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .edit_sel(edit_sel),
        .out(out_a), .out_valid(valid_a)
    );

    lcd_text_frame_gen #(.COLS(20), .ROWS(2), .IDX_W(6), .TIME_ROW(T_ROW), .TIME_COL(T_COL),
                         .BLINK_DIV(BDIV)) u_dut20 (
        .clk(clk), .rst(rst), .req(req20), .index(index20), .mode(mode),
        .hr_bcd(hr_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .edit_sel(edit_sel),
        .out(out_b), .out_valid(valid_b)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; the blink phase is its BDIV-sized half-period parity.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dig(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : 8'h30 + 8'(d);
    endfunction

    function automatic logic phase_now();
`ifdef LCD_BLINK_EN
        return ((cyc / BDIV) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic snap_t grab();
        snap_t s;
        s.mode  = mode;
        s.hr    = hr_bcd;
        s.mn    = min_bcd;
        s.sc    = sec_bcd;
        s.edit  = edit_sel;
        s.phase = phase_now();
        return s;
    endfunction

    function automatic logic [7:0] model_char(input int cols, input int rows, input int idx,
                                              input snap_t s);
        string      ban [2];
        logic [7:0] t [8];
        int         r, c, grp;
        ban[0] = "20173291        ";
        ban[1] = "Bae Hyeon Han   ";
        if (idx >= cols * rows) return 8'h20;
        r = idx / cols;
        c = idx % cols;
        t[0] = dig(s.hr[7:4]); t[1] = dig(s.hr[3:0]); t[2] = 8'h3A;
        t[3] = dig(s.mn[7:4]); t[4] = dig(s.mn[3:0]); t[5] = 8'h3A;
        t[6] = dig(s.sc[7:4]); t[7] = dig(s.sc[3:0]);
        if (s.edit != 2'd0 && s.phase) begin
            grp = 3 - int'(s.edit);
            t[grp*3]   = 8'h20;
            t[grp*3+1] = 8'h20;
        end
        if (s.mode == 2'd3) return 8'h20;
        if (s.mode != 2'd0 && r == T_ROW && c >= T_COL && c < T_COL + 8) return t[c - T_COL];
        if (s.mode == 2'd1) return 8'h20;
        if (r < 2 && c < 16) return ban[r][c];
        return 8'h20;
    endfunction

    function automatic logic [7:0] rnd_bcd(input int max_tens);
        logic [3:0] hi, lo;
        hi = 4'($urandom_range(0, max_tens));
        lo = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 5) == 0) lo = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) hi = 4'($urandom_range(10, 15));
        return {hi, lo};
    endfunction

    task automatic rnd_inputs();
        mode     = 2'($urandom_range(0, 3));
        hr_bcd   = rnd_bcd(2);
        min_bcd  = rnd_bcd(5);
        sec_bcd  = rnd_bcd(5);
        edit_sel = 2'($urandom_range(0, 3));
    endtask

    // Called at a falling edge; the result is checked at the next falling edge.
    task automatic send(input int idx);
        logic [7:0] exp;
        req   = 1'b1;
        index = 5'(idx);
        if (idx == 0) s_a = grab();
        exp = model_char(16, 2, idx, s_a);
        @(negedge clk);
        check1($sformatf("valid16[%0d]", idx), valid_a, 1'b1);
        check8($sformatf("char16[%0d]", idx), out_a, exp);
        last_a = exp;
        req = 1'b0;
    endtask

    task automatic send20(input int idx);
        logic [7:0] exp;
        req20   = 1'b1;
        index20 = 6'(idx);
        if (idx == 0) s_b = grab();
        exp = model_char(20, 2, idx, s_b);
        @(negedge clk);
        check1($sformatf("valid20[%0d]", idx), valid_b, 1'b1);
        check8($sformatf("char20[%0d]", idx), out_b, exp);
        last_b = exp;
        req20 = 1'b0;
    endtask

    task automatic idle();
        req   = 1'b0;
        req20 = 1'b0;
        @(negedge clk);
        check1("idle_valid16", valid_a, 1'b0);
        check8("idle_hold16", out_a, last_a);
        check1("idle_valid20", valid_b, 1'b0);
        check8("idle_hold20", out_b, last_b);
    endtask

    initial begin
        s_a    = '0;
        s_b    = '0;
        last_a = 8'h00;
        last_b = 8'h00;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check8("rst_out16", out_a, 8'h00);
        check1("rst_valid16", valid_a, 1'b0);
        check8("rst_out20", out_b, 8'h00);
        check1("rst_valid20", valid_b, 1'b0);
        rst = 1'b1;

        // First request after reset: banner '2'
        mode = 2'd0;
        send(0);
        check8("first_char", out_a, 8'h32);
        idle();

        // Clock mode sweep at 12:34:56
        mode = 2'd1; hr_bcd = 8'h12; min_bcd = 8'h34; sec_bcd = 8'h56; edit_sel = 2'd0;
        for (int i = 0; i < 32; i++) send(i);
        idle();

        // Inputs change mid-frame; only the following frame sees them
        mode = 2'd2; hr_bcd = 8'h09; min_bcd = 8'h59; sec_bcd = 8'h59;
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin hr_bcd = 8'h10; min_bcd = 8'h00; sec_bcd = 8'h00; end
            send(i);
            if (i == 16) check8("midframe_hr_tens", out_a, 8'h30);
        end
        for (int i = 0; i < 32; i++) begin
            send(i);
            if (i == 16) check8("nextframe_hr_tens", out_a, 8'h31);
        end

        // Non-BCD nibble and last index
        mode = 2'd1; sec_bcd = 8'h5A;
        send(0);
        send(23); check8("bad_nibble", out_a, 8'h3F);
        send(22); check8("good_tens", out_a, 8'h35);
        send(31); check8("last_idx", out_a, 8'h20);

        // Minute field under edit across several blink phases
        mode = 2'd1; hr_bcd = 8'h08; min_bcd = 8'h47; sec_bcd = 8'h15; edit_sel = 2'd2;
        for (int f = 0; f < 6; f++) begin
            send(0); send(19); send(20); send(21);
            idle();
            if (f % 2 == 1) idle();
        end

        // Randomized frames with gaps and mid-frame input churn
        for (int f = 0; f < 10; f++) begin
            rnd_inputs();
            for (int i = 0; i < 32; i++) begin
                if ($urandom_range(0, 7) == 0) rnd_inputs();
                if ($urandom_range(0, 4) == 0) idle();
                send(i);
            end
            for (int k = 0; k < 12; k++) send($urandom_range(1, 31));
        end

        // 20-column build, including indices beyond the frame
        for (int f = 0; f < 3; f++) begin
            rnd_inputs();
            if (f == 0) mode = 2'd2;
            if (f == 1) mode = 2'd0;
            for (int i = 0; i < 64; i++) send20(i);
        end
        send20(39); check8("idx39_20col", out_b, 8'h20);
        idle();

        // Reset asserted mid-frame
        mode = 2'd1; hr_bcd = 8'h11; min_bcd = 8'h22; sec_bcd = 8'h33; edit_sel = 2'd0;
        for (int i = 0; i < 7; i++) send(i);
        req = 1'b1; index = 5'd7;
        #2 rst = 1'b0;
        #1;
        check8("midrst_out", out_a, 8'h00);
        check1("midrst_valid", valid_a, 1'b0);
        s_a = '0; s_b = '0; last_a = 8'h00; last_b = 8'h00;
        @(negedge clk);
        req = 1'b0;
        check8("midrst_out_hold", out_a, 8'h00);
        check1("midrst_valid_hold", valid_a, 1'b0);
        rst = 1'b1;
        send(16); check8("post_rst_default", out_a, 8'h42);
        send(20);
        send(0);  check8("post_rst_newframe", out_a, 8'h20);
        send(16); check8("post_rst_time", out_a, 8'h31);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
